// File: rtl/fp_div.sv
// Sequential IEEE-754 binary32 divider: radix-2 restoring mantissa divide behind a
// start/done handshake, fixed 28-cycle latency, truncating, denormals flushed to zero.
module fp_div #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MAN_W  = 23,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned BIAS   = 127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              overflow,
    output logic              underflow,
    output logic              exception,
    output logic [DATA_W-1:0] res
);

    typedef enum logic [1:0] {StIdle, StUnpack, StDiv, StPack} state_e;

    localparam logic [EXP_W-1:0] ExpMax = {EXP_W{1'b1}};

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [MAN_W:0]      mb_q;
    logic [MAN_W+1:0]    rem_q, q_q;
    logic [4:0]          cnt_q;
    logic signed [9:0]   exp_q;
    logic                sign_q;
    logic [DATA_W-1:0]   res_q, res_n;
    logic                ovf_q, unf_q, exc_q, done_q;
    logic                ovf_n, unf_n, exc_n;

    // FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StUnpack;
            StUnpack: state_d = StDiv;
            StDiv:    if (cnt_q == 5'd0) state_d = StPack;
            StPack:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    assign busy = (state_q != StIdle);

    // Restoring step
    logic                rem_ge;
    logic [MAN_W+1:0]    rem_sub;
    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    // Operand classification
    logic [EXP_W-1:0] a_exp, b_exp;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign a_exp  = a_q[DATA_W-2:MAN_W];
    assign b_exp  = b_q[DATA_W-2:MAN_W];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == ExpMax) && (a_q[MAN_W-1:0] == '0);
    assign b_inf  = (b_exp == ExpMax) && (b_q[MAN_W-1:0] == '0);
    assign a_nan  = (a_exp == ExpMax) && (a_q[MAN_W-1:0] != '0);
    assign b_nan  = (b_exp == ExpMax) && (b_q[MAN_W-1:0] != '0);

    logic signed [9:0] norm_exp;
    logic [MAN_W-1:0]  norm_man;

    always_comb begin
        norm_exp = q_q[MAN_W+1] ? exp_q : exp_q - 10'sd1;
        norm_man = q_q[MAN_W+1] ? q_q[MAN_W:1] : q_q[MAN_W-1:0];
        res_n    = {sign_q, norm_exp[EXP_W-1:0], norm_man};
        ovf_n    = 1'b0;
        unf_n    = 1'b0;
        exc_n    = 1'b0;
        if (norm_exp > 10'sd254) begin
            res_n = {sign_q, ExpMax, {MAN_W{1'b0}}};
            ovf_n = 1'b1;
        end else if (norm_exp < 10'sd1) begin
            res_n = {sign_q, {(DATA_W-1){1'b0}}};
            unf_n = 1'b1;
        end
        // Special operands override the range checks
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_n = 32'h7FC0_0000;
            {ovf_n, unf_n, exc_n} = 3'b001;
        end else if (b_zero && !a_inf) begin
            res_n = {sign_q, ExpMax, {MAN_W{1'b0}}};
            {ovf_n, unf_n, exc_n} = 3'b001;
        end else if (a_inf) begin
            res_n = {sign_q, ExpMax, {MAN_W{1'b0}}};
            {ovf_n, unf_n, exc_n} = 3'b000;
        end else if (a_zero || b_inf) begin
            res_n = {sign_q, {(DATA_W-1){1'b0}}};
            {ovf_n, unf_n, exc_n} = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mb_q   <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            exc_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q <= op_a;
                        b_q <= op_b;
                    end
                end
                StUnpack: begin
                    rem_q  <= {2'b01, a_q[MAN_W-1:0]};
                    mb_q   <= {1'b1, b_q[MAN_W-1:0]};
                    exp_q  <= {2'b00, a_exp} - {2'b00, b_exp} + 10'(BIAS);
                    sign_q <= a_q[DATA_W-1] ^ b_q[DATA_W-1];
                    cnt_q  <= 5'd24;
                    q_q    <= '0;
                end
                StDiv: begin
                    q_q[cnt_q] <= rem_ge;
                    rem_q      <= {rem_sub[MAN_W:0], 1'b0};
                    cnt_q      <= cnt_q - 5'd1;
                end
                StPack: begin
                    res_q  <= res_n;
                    ovf_q  <= ovf_n;
                    unf_q  <= unf_n;
                    exc_q  <= exc_n;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign res       = res_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign exception = exc_q;
    assign done      = done_q;

endmodule
